gshare_predictor: RTL and testbench



---
 rtl/gshare_predictor.sv | 129 ++++++++++++
 tb/tb_gshare_predictor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare direction predictor: a table of saturating counters indexed by
// PC bits XORed with a speculative global history register. The history is
// checkpointed per prediction (PD_History) and repaired from that checkpoint
// when the JB stage reports a mispredict. The table is cleared by a
// sequential walk after reset instead of a per-entry asynchronous reset.
module gshare_predictor #(
   parameter int TABLE_WIDTH = 6,
   parameter int HISTORY_LEN = 6,
   parameter int CTR_WIDTH   = 2,
   parameter bit USE_HISTORY = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   PD_Valid,
   input  logic [TABLE_WIDTH-1:0] PD_PC_Slice,
   output logic                   PD_PredictTaken,
   output logic [TABLE_WIDTH-1:0] PD_Index,
   output logic [HISTORY_LEN-1:0] PD_History,
   input  logic                   JB_AttemptBranch,
   input  logic                   JB_BranchTaken,
   input  logic                   JB_Mispredict,
   input  logic [TABLE_WIDTH-1:0] JB_Index,
   input  logic [HISTORY_LEN-1:0] JB_History,
   output logic                   Ready
);

   localparam int DEPTH = 2 ** TABLE_WIDTH;

   // Weakly-not-taken: MSB clear, all lower bits set.
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = {1'b0, {(CTR_WIDTH-1){1'b1}}};
   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
   localparam logic [CTR_WIDTH-1:0] CTR_MIN  = {CTR_WIDTH{1'b0}};

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [TABLE_WIDTH-1:0] init_idx_q;
   logic [TABLE_WIDTH-1:0] init_idx_d;
   logic [HISTORY_LEN-1:0] ghr_q;
   logic [HISTORY_LEN-1:0] ghr_d;
   logic [CTR_WIDTH-1:0]   ctr_table [DEPTH];
   logic [CTR_WIDTH-1:0]   upd_ctr;
   logic                   run;

   // Counter increment that sticks at all-ones.
   function automatic logic [CTR_WIDTH-1:0] sat_inc(input logic [CTR_WIDTH-1:0] ctr);
      return (ctr == CTR_MAX) ? ctr : ctr + CTR_WIDTH'(1);
   endfunction

   // Counter decrement that sticks at zero.
   function automatic logic [CTR_WIDTH-1:0] sat_dec(input logic [CTR_WIDTH-1:0] ctr);
      return (ctr == CTR_MIN) ? ctr : ctr - CTR_WIDTH'(1);
   endfunction

   // Shift a new outcome into the LSB; the oldest bit falls off the top.
   // The truncating cast also covers HISTORY_LEN == 1 (history = outcome).
   function automatic logic [HISTORY_LEN-1:0] shift_in(input logic [HISTORY_LEN-1:0] hist,
                                                        input logic                   outcome);
      return HISTORY_LEN'({hist, outcome});
   endfunction

   assign run   = (state_q == ST_RUN);
   assign Ready = run;

   // History is zero-extended into the low index bits; bimodal mode ignores it.
   assign PD_Index   = USE_HISTORY ? (PD_PC_Slice ^ TABLE_WIDTH'(ghr_q)) : PD_PC_Slice;
   assign PD_History = ghr_q;

   // Read sees the pre-update table contents; no write bypass.
   assign PD_PredictTaken = run & ctr_table[PD_Index][CTR_WIDTH-1];

   // Resolved-branch counter value to be written back at JB_Index.
   assign upd_ctr = JB_BranchTaken ? sat_inc(ctr_table[JB_Index]) : sat_dec(ctr_table[JB_Index]);

   // Control state: FSM, init walk pointer and global history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         init_idx_q <= '0;
         ghr_q      <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
         ghr_q      <= ghr_d;
      end
   end

   // Next-state: init walk, then history repair/speculative shift in RUN.
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      ghr_d      = ghr_q;
      case (state_q)
         ST_INIT: begin
            ghr_d      = '0;
            init_idx_d = init_idx_q + TABLE_WIDTH'(1);
            if (&init_idx_q) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A mispredict flushes any younger branch predicted this cycle,
            // so the repair wins over the speculative shift.
            if (JB_AttemptBranch && JB_Mispredict) begin
               ghr_d = shift_in(JB_History, JB_BranchTaken);
            end else if (PD_Valid) begin
               ghr_d = shift_in(ghr_q, PD_PredictTaken);
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Counter table: init walk writes one entry per cycle, RUN applies resolutions.
   always_ff @(posedge clk) begin
      if (!run) begin
         ctr_table[init_idx_q] <= CTR_INIT;
      end else if (JB_AttemptBranch) begin
         ctr_table[JB_Index] <= upd_ctr;
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor (TABLE_WIDTH=3, HISTORY_LEN=3,
// CTR_WIDTH=2). A second instance with USE_HISTORY=0 shares the inputs.
module tb_gshare_predictor;

   localparam int TW = 3;
   localparam int HL = 3;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pd_valid;
   logic [TW-1:0] pd_pc_slice;
   logic          pd_predict_taken;
   logic [TW-1:0] pd_index;
   logic [HL-1:0] pd_history;
   logic          jb_attempt;
   logic          jb_taken;
   logic          jb_mispredict;
   logic [TW-1:0] jb_index;
   logic [HL-1:0] jb_history;
   logic          ready;

   logic          b_predict_taken;
   logic [TW-1:0] b_index;
   logic [HL-1:0] b_history;
   logic          b_ready;

   int checks = 0;
   int errors = 0;

   // Free-running clock, posedges at 5, 15, 25, ...
   always #5 clk = ~clk;

   gshare_predictor #(
      .TABLE_WIDTH(TW), .HISTORY_LEN(HL), .CTR_WIDTH(CW), .USE_HISTORY(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .PD_Valid(pd_valid), .PD_PC_Slice(pd_pc_slice),
      .PD_PredictTaken(pd_predict_taken), .PD_Index(pd_index), .PD_History(pd_history),
      .JB_AttemptBranch(jb_attempt), .JB_BranchTaken(jb_taken), .JB_Mispredict(jb_mispredict),
      .JB_Index(jb_index), .JB_History(jb_history), .Ready(ready)
   );

   gshare_predictor #(
      .TABLE_WIDTH(TW), .HISTORY_LEN(HL), .CTR_WIDTH(CW), .USE_HISTORY(1'b0)
   ) dut_bim (
      .clk(clk), .rst_n(rst_n),
      .PD_Valid(pd_valid), .PD_PC_Slice(pd_pc_slice),
      .PD_PredictTaken(b_predict_taken), .PD_Index(b_index), .PD_History(b_history),
      .JB_AttemptBranch(jb_attempt), .JB_BranchTaken(jb_taken), .JB_Mispredict(jb_mispredict),
      .JB_Index(jb_index), .JB_History(jb_history), .Ready(b_ready)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pd_valid      = 1'b0;
      pd_pc_slice   = '0;
      jb_attempt    = 1'b0;
      jb_taken      = 1'b0;
      jb_mispredict = 1'b0;
      jb_index      = '0;
      jb_history    = '0;
   endtask

   task automatic resolve(input logic [TW-1:0] idx, input logic taken);
      jb_attempt    = 1'b1;
      jb_mispredict = 1'b0;
      jb_index      = idx;
      jb_taken      = taken;
   endtask

   // Guard against a hung run.
   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] sat_exp;
      logic [2:0] pre_idx [3];
      pre_idx = '{3'd0, 3'd1, 3'd3};
      sat_exp = 8'b0001_1111;

      // ---- reset state, with INIT-time inputs that must be ignored ----
      rst_n         = 1'b0;
      idle();
      pd_valid      = 1'b1;
      pd_pc_slice   = 3'd5;
      jb_attempt    = 1'b1;
      jb_taken      = 1'b1;
      jb_mispredict = 1'b1;
      jb_index      = 3'd2;
      jb_history    = 3'b111;
      repeat (3) tick();
      #1;
      check("rst_ready", ready, 0);
      check("rst_pred", pd_predict_taken, 0);
      check("rst_hist", pd_history, 0);
      check("rst_index", pd_index, 5);

      // ---- INIT lasts 8 cycles after release ----
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         check($sformatf("init_ready_c%0d", c), ready, (c == 8) ? 1 : 0);
         if (c == 7) begin
            check("init_ghr_held", pd_history, 0);
            idle();
         end
      end

      // ---- every entry starts weakly not taken ----
      for (int s = 0; s < 8; s++) begin
         pd_pc_slice = 3'(s);
         #1;
         check($sformatf("init_pred_s%0d", s), pd_predict_taken, 0);
         check($sformatf("init_index_s%0d", s), pd_index, s);
      end

      // Entry 2 must still be 01: one taken update makes it 10 (predict 1).
      resolve(3'd2, 1'b1);
      tick();
      jb_attempt  = 1'b0;
      pd_pc_slice = 3'd2;
      #1;
      check("init_jb_ignored", pd_predict_taken, 1);
      resolve(3'd2, 1'b0);
      tick();
      jb_attempt = 1'b0;
      #1;
      check("entry2_restored", pd_predict_taken, 0);

      // ---- saturation on entry 5: 4x taken then 4x not taken ----
      for (int i = 0; i < 8; i++) begin
         resolve(3'd5, (i < 4));
         pd_pc_slice = 3'd5;
         tick();
         jb_attempt = 1'b0;
         #1;
         check($sformatf("sat_step%0d", i), pd_predict_taken, sat_exp[i]);
      end

      // ---- preset entries 0,1,3 to 10 ----
      for (int i = 0; i < 3; i++) begin
         resolve(pre_idx[i], 1'b1);
         tick();
      end
      idle();

      // ---- GHR shift on three taken predictions ----
      pd_valid    = 1'b1;
      pd_pc_slice = 3'd0;
      #1;
      check("ghr0_hist", pd_history, 3'b000);
      check("ghr0_index", pd_index, 0);
      check("ghr0_pred", pd_predict_taken, 1);
      tick();
      check("ghr1_hist", pd_history, 3'b001);
      check("ghr1_index", pd_index, 1);
      check("ghr1_pred", pd_predict_taken, 1);
      tick();
      check("ghr2_hist", pd_history, 3'b011);
      check("ghr2_index", pd_index, 3);
      check("ghr2_pred", pd_predict_taken, 1);
      tick();
      pd_valid = 1'b0;
      #1;
      check("ghr3_hist", pd_history, 3'b111);
      pd_pc_slice = 3'b101;
      #1;
      check("ghr_xor_index", pd_index, 3'b010);
      check("bim_index", b_index, 3'b101);
      check("bim_hist", b_history, 3'b111);

      // ---- mispredict repair beats a same-cycle prediction shift ----
      jb_attempt    = 1'b1;
      jb_mispredict = 1'b1;
      jb_taken      = 1'b0;
      jb_history    = 3'b110;
      jb_index      = 3'd6;
      pd_valid      = 1'b1;
      tick();
      idle();
      #1;
      check("repair_hist", pd_history, 3'b100);

      // ---- same-cycle read/write of entry 4 (01 -> 10), no bypass ----
      pd_pc_slice = 3'd0;
      resolve(3'd4, 1'b1);
      #1;
      check("rw_index", pd_index, 4);
      check("rw_pred_before", pd_predict_taken, 0);
      tick();
      jb_attempt = 1'b0;
      #1;
      check("rw_pred_after", pd_predict_taken, 1);
      check("correct_no_ghr", pd_history, 3'b100);

      // ---- asynchronous reset mid-RUN ----
      rst_n = 1'b0;
      #1;
      check("async_ready", ready, 0);
      check("async_hist", pd_history, 0);
      check("async_pred", pd_predict_taken, 0);
      tick();
      tick();

      // ---- reset again at init index 4; INIT must restart from 0 ----
      rst_n = 1'b1;
      repeat (4) tick();
      check("midinit_ready", ready, 0);
      rst_n = 1'b0;
      #1;
      check("midinit_rst_ready", ready, 0);
      tick();
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         check($sformatf("reinit_ready_c%0d", c), ready, (c == 8) ? 1 : 0);
      end

      // Entries written before the aborted walk are back to 01.
      pd_pc_slice = 3'd4;
      #1;
      check("reinit_index4", pd_index, 4);
      check("reinit_pred4", pd_predict_taken, 0);
      pd_pc_slice = 3'd0;
      #1;
      check("reinit_pred0", pd_predict_taken, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
